// File: rtl/writeback_arbiter_if.sv
// Execute-pipe result streams into the writeback arbiter, and its register-file,
// issue-stall and hazard outputs.
interface writeback_arbiter_if;
  logic        x_wb_writereg;
  logic [4:0]  x_wb_regdest;
  logic [31:0] x_wb_wbvalue;
  logic        y_wb_writereg;
  logic [4:0]  y_wb_regdest;
  logic [31:0] y_wb_wbvalue;
  logic        wb_rf_writereg;
  logic [4:0]  wb_rf_regdest;
  logic [31:0] wb_rf_wbvalue;
  logic        wb_is_ystall;
  logic [31:0] wb_is_pending;
  logic        wb_overflow;

  modport master (
    output x_wb_writereg, x_wb_regdest, x_wb_wbvalue,
    output y_wb_writereg, y_wb_regdest, y_wb_wbvalue,
    input  wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue,
    input  wb_is_ystall, wb_is_pending, wb_overflow
  );

  modport slave (
    input  x_wb_writereg, x_wb_regdest, x_wb_wbvalue,
    input  y_wb_writereg, y_wb_regdest, y_wb_wbvalue,
    output wb_rf_writereg, wb_rf_regdest, wb_rf_wbvalue,
    output wb_is_ystall, wb_is_pending, wb_overflow
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the X (ALU) and Y (multiply) result streams onto one register-file write
// port. X always wins; colliding Y results wait in a FIFO and are squashed by younger X writes.
module writeback_arbiter #(
  parameter int DEPTH = 8,
  parameter int Y_LAT = 4
) (
  input logic                clock,
  input logic                reset,
  writeback_arbiter_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t              count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d, kill_q, kill_d;
  logic [4:0]        mem_dest_q [DEPTH];
  logic [31:0]       mem_val_q  [DEPTH];
  logic              out_we_q, out_we_d;
  logic [4:0]        out_dest_q, out_dest_d;
  logic [31:0]       out_val_q, out_val_d;
  logic              stall_q, stall_d;
  logic              ovf_q, ovf_d;
  logic              push_en, pop_en;
  logic              x_vld, y_vld;
  logic [31:0]       pending;

  assign x_vld = wb.x_wb_writereg && (wb.x_wb_regdest != '0);
  assign y_vld = wb.y_wb_writereg && (wb.y_wb_regdest != '0);

  // NOTE: every combinational output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    vld_d      = vld_q;
    kill_d     = kill_q;
    out_we_d   = 1'b0;
    out_dest_d = out_dest_q;
    out_val_d  = out_val_q;
    ovf_d      = ovf_q;
    push_en    = 1'b0;
    pop_en     = 1'b0;

    // A younger X write makes every older queued write to the same register dead.
    if (x_vld) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && mem_dest_q[i] == wb.x_wb_regdest) kill_d[i] = 1'b1;
      end
    end

    if (x_vld) begin
      out_we_d   = 1'b1;
      out_dest_d = wb.x_wb_regdest;
      out_val_d  = wb.x_wb_wbvalue;
      if (y_vld) begin
        if (count_q != cnt_t'(DEPTH)) push_en = 1'b1;
        else                          ovf_d   = 1'b1;
      end
    end else if (count_q != '0) begin
      pop_en           = 1'b1;
      vld_d[rd_ptr_q]  = 1'b0;
      kill_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ptr_t'(rd_ptr_q + 1'b1);
      if (!kill_q[rd_ptr_q]) begin
        out_we_d   = 1'b1;
        out_dest_d = mem_dest_q[rd_ptr_q];
        out_val_d  = mem_val_q[rd_ptr_q];
      end
      push_en = y_vld;
    end else if (y_vld) begin
      out_we_d   = 1'b1;
      out_dest_d = wb.y_wb_regdest;
      out_val_d  = wb.y_wb_wbvalue;
    end

    // Push is applied after pop so a full FIFO can reuse the slot freed this cycle.
    if (push_en) begin
      vld_d[wr_ptr_q]  = 1'b1;
      kill_d[wr_ptr_q] = x_vld && (wb.y_wb_regdest == wb.x_wb_regdest);
      wr_ptr_d         = ptr_t'(wr_ptr_q + 1'b1);
    end

    case ({push_en, pop_en})
      2'b10:   count_d = cnt_t'(count_q + 1'b1);
      2'b01:   count_d = cnt_t'(count_q - 1'b1);
      default: count_d = count_q;
    endcase

    stall_d = (count_d >= cnt_t'(DEPTH - Y_LAT));
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      kill_q     <= '0;
      out_we_q   <= 1'b0;
      out_dest_q <= '0;
      out_val_q  <= '0;
      stall_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      vld_q      <= vld_d;
      kill_q     <= kill_d;
      out_we_q   <= out_we_d;
      out_dest_q <= out_dest_d;
      out_val_q  <= out_val_d;
      stall_q    <= stall_d;
      ovf_q      <= ovf_d;
    end
  end

  // NOTE: the payload storage is deliberately not reset; the valid flags alone
  // decide whether an entry is live, which keeps the data RAM-mappable.
  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_dest_q[wr_ptr_q] <= wb.y_wb_regdest;
      mem_val_q[wr_ptr_q]  <= wb.y_wb_wbvalue;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !kill_q[i]) pending[mem_dest_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign wb.wb_rf_writereg = out_we_q;
  assign wb.wb_rf_regdest  = out_dest_q;
  assign wb.wb_rf_wbvalue  = out_val_q;
  assign wb.wb_is_ystall   = stall_q;
  assign wb.wb_is_pending  = pending;
  assign wb.wb_overflow    = ovf_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: stimulus queues the expected register-file
// writes, a negedge monitor pops and compares each write the DUT performs.
module tb_writeback_arbiter;
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] val;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  wr_t  exp_q[$];

  writeback_arbiter_if bus ();

  writeback_arbiter #(.DEPTH(8), .Y_LAT(4)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] dest, input logic [31:0] val);
    wr_t w;
    w.dest = dest;
    w.val  = val;
    exp_q.push_back(w);
  endtask

  task automatic cyc(input logic xv, input logic [4:0] xr, input logic [31:0] xd,
                     input logic yv, input logic [4:0] yr, input logic [31:0] yd);
    bus.x_wb_writereg = xv;
    bus.x_wb_regdest  = xr;
    bus.x_wb_wbvalue  = xd;
    bus.y_wb_writereg = yv;
    bus.y_wb_regdest  = yr;
    bus.y_wb_wbvalue  = yd;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clock) begin
    if (bus.wb_rf_writereg === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write_dest", {27'd0, bus.wb_rf_regdest}, 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_dest", {27'd0, bus.wb_rf_regdest}, {27'd0, w.dest});
        check("wr_value", bus.wb_rf_wbvalue, w.val);
      end
    end
  end

  initial begin
    bus.x_wb_writereg = 1'b0;
    bus.x_wb_regdest  = '0;
    bus.x_wb_wbvalue  = '0;
    bus.y_wb_writereg = 1'b0;
    bus.y_wb_regdest  = '0;
    bus.y_wb_wbvalue  = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_writereg", {31'd0, bus.wb_rf_writereg}, 32'd0);
    check("rst_regdest",  {27'd0, bus.wb_rf_regdest}, 32'd0);
    check("rst_wbvalue",  bus.wb_rf_wbvalue, 32'd0);
    check("rst_ystall",   {31'd0, bus.wb_is_ystall}, 32'd0);
    check("rst_overflow", {31'd0, bus.wb_overflow}, 32'd0);
    check("rst_pending",  bus.wb_is_pending, 32'd0);
    reset = 1'b1;

    // X only
    expect_wr(5'd5, 32'hDEADBEEF);
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    check("xonly_pending", bus.wb_is_pending, 32'd0);
    idle(1);

    // Y bypass on empty FIFO
    expect_wr(5'd7, 32'h12345678);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
    check("bypass_pending", bus.wb_is_pending, 32'd0);
    idle(1);

    // Collision: X first, queued Y next cycle
    expect_wr(5'd3, 32'h1);
    expect_wr(5'd4, 32'h2);
    cyc(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    check("collide_pending_set", bus.wb_is_pending, 32'h0000_0010);
    idle(1);
    check("collide_pending_clr", bus.wb_is_pending, 32'd0);
    idle(1);

    // Squash: queued r9 is overwritten by younger X r9
    expect_wr(5'd1, 32'h11);
    cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
    check("squash_pending_set", bus.wb_is_pending, 32'h0000_0200);
    expect_wr(5'd9, 32'hAA);
    cyc(1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 32'd0);
    check("squash_pending_clr", bus.wb_is_pending, 32'd0);
    idle(1);
    check("squash_killed_pop", {31'd0, bus.wb_rf_writereg}, 32'd0);
    idle(1);

    // Same-cycle collision where Y targets the X register: pushed already killed
    expect_wr(5'd12, 32'hC0);
    cyc(1'b1, 5'd12, 32'hC0, 1'b1, 5'd12, 32'hC1);
    check("samecyc_kill_pending", bus.wb_is_pending, 32'd0);
    idle(1);
    check("samecyc_kill_pop", {31'd0, bus.wb_rf_writereg}, 32'd0);
    idle(1);

    // r0 writes are discarded; invalid X lets Y bypass
    cyc(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 32'hBAD1);
    check("r0_no_write", {31'd0, bus.wb_rf_writereg}, 32'd0);
    expect_wr(5'd6, 32'h66);
    cyc(1'b1, 5'd0, 32'hBAD2, 1'b1, 5'd6, 32'h66);
    idle(1);

    // Simultaneous push and pop keeps count constant
    expect_wr(5'd2, 32'h22);
    expect_wr(5'd3, 32'h33);
    expect_wr(5'd4, 32'h44);
    cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
    check("pushpop_pending", bus.wb_is_pending, 32'h0000_0010);
    idle(2);
    check("pushpop_drained", bus.wb_is_pending, 32'd0);

    // Stall threshold and overflow with X+Y every cycle
    for (int k = 1; k <= 9; k++) begin
      expect_wr(5'(k + 10), 32'h1000 + k);
      cyc(1'b1, 5'(k + 10), 32'h1000 + k, 1'b1, 5'(k + 20), 32'h2000 + k);
      check($sformatf("ystall_k%0d", k), {31'd0, bus.wb_is_ystall}, {31'd0, (k >= 4)});
      check($sformatf("overflow_k%0d", k), {31'd0, bus.wb_overflow}, {31'd0, (k == 9)});
    end
    check("full_pending", bus.wb_is_pending, 32'h1FE0_0000);
    for (int k = 1; k <= 8; k++) expect_wr(5'(k + 20), 32'h2000 + k);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      check($sformatf("drain_ystall_%0d", k), {31'd0, bus.wb_is_ystall}, {31'd0, (k <= 4)});
    end
    check("overflow_sticky", {31'd0, bus.wb_overflow}, 32'd1);
    check("drain_pending", bus.wb_is_pending, 32'd0);

    // Reset mid-operation with three entries queued
    for (int k = 1; k <= 3; k++) begin
      expect_wr(5'(k + 10), 32'h3000 + k);
      cyc(1'b1, 5'(k + 10), 32'h3000 + k, 1'b1, 5'(k + 13), 32'h4000 + k);
    end
    check("pre_reset_pending", bus.wb_is_pending, 32'h0001_C000);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("mid_rst_writereg", {31'd0, bus.wb_rf_writereg}, 32'd0);
    check("mid_rst_regdest",  {27'd0, bus.wb_rf_regdest}, 32'd0);
    check("mid_rst_wbvalue",  bus.wb_rf_wbvalue, 32'd0);
    check("mid_rst_ystall",   {31'd0, bus.wb_is_ystall}, 32'd0);
    check("mid_rst_overflow", {31'd0, bus.wb_overflow}, 32'd0);
    check("mid_rst_pending",  bus.wb_is_pending, 32'd0);
    expect_wr(5'd20, 32'h5555);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h5555);
    check("post_rst_bypass_pending", bus.wb_is_pending, 32'd0);
    idle(6);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
